asic_ioring_ctrl: RTL and testbench

ASIC_IORING_CTRL -- requirements
Module: asic_ioring_ctrl

---
 rtl/asic_ioring_ctrl.sv | 146 ++++++++++++++
 tb/tb_asic_ioring_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/asic_ioring_ctrl.sv
// Pad-ring ctrl sequencer: ramps a thermometer-coded enable ring up/down in
// dly+1 cycle steps, gated by a synchronized IO-supply-good sense.
//
// state   | meaning
// IDLE    | ring off, waiting for en
// WAIT_OK | en seen, waiting for supply good (bounded by tmo)
// RAMP    | setting ctrl bits LSB first, one per step
// ON      | ring fully enabled
// RAMPDN  | clearing ctrl bits MSB first, one per step
// FAULT   | supply lost or power-up timeout; held until en drops
module asic_ioring_ctrl #(
    parameter int NCTRL = 8,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic             sense_ok,
    input  logic [CW-1:0]    dly,
    output logic [NCTRL-1:0] ctrl,
    output logic             ready,
    output logic             busy,
    output logic             fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_OK,
        S_RAMP,
        S_ON,
        S_RAMPDN,
        S_FAULT
    } state_t;

    localparam logic [CW-1:0]    TMO_MAX  = '1;
    localparam logic [NCTRL-1:0] ALL_ONES = '1;

    state_t           state, state_n;
    logic [NCTRL-1:0] ctrl_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [CW-1:0]    tmo, tmo_n;
    logic [CW-1:0]    dly_q, dly_n;
    logic             sense_m, sense_s;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sense_m <= 1'b0;
            sense_s <= 1'b0;
            state   <= S_IDLE;
            ctrl    <= '0;
            cnt     <= '0;
            tmo     <= '0;
            dly_q   <= '0;
        end else begin
            sense_m <= sense_ok;
            sense_s <= sense_m;
            state   <= state_n;
            ctrl    <= ctrl_n;
            cnt     <= cnt_n;
            tmo     <= tmo_n;
            dly_q   <= dly_n;
        end
    end

    always_comb begin
        state_n = state;
        ctrl_n  = ctrl;
        cnt_n   = cnt;
        tmo_n   = tmo;
        dly_n   = dly_q;
        case (state)
            S_IDLE: begin
                ctrl_n = '0;
                if (en) begin
                    state_n = S_WAIT_OK;
                    dly_n   = dly;
                    tmo_n   = '0;
                end
            end
            S_WAIT_OK: begin
                if (!en) begin
                    state_n = S_IDLE;
                end else if (sense_s) begin
                    state_n = S_RAMP;
                    cnt_n   = '0;
                end else if (tmo == TMO_MAX - 1'b1) begin
                    state_n = S_FAULT;
                    tmo_n   = TMO_MAX;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            S_RAMP: begin
                if (!sense_s) begin
                    state_n = S_FAULT;
                    ctrl_n  = '0;
                end else if (!en) begin
                    state_n = S_RAMPDN;
                    cnt_n   = '0;
                end else if (cnt == dly_q) begin
                    ctrl_n = {ctrl[NCTRL-2:0], 1'b1};
                    cnt_n  = '0;
                    // the step that fills the top bit lands directly in ON
                    if (&ctrl[NCTRL-2:0]) state_n = S_ON;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_ON: begin
                ctrl_n = ALL_ONES;
                if (!sense_s) begin
                    state_n = S_FAULT;
                    ctrl_n  = '0;
                end else if (!en) begin
                    state_n = S_RAMPDN;
                    cnt_n   = '0;
                end
            end
            S_RAMPDN: begin
                if (!sense_s) begin
                    state_n = S_FAULT;
                    ctrl_n  = '0;
                end else if (cnt == dly_q) begin
                    ctrl_n = {1'b0, ctrl[NCTRL-1:1]};
                    cnt_n  = '0;
                    if (ctrl[NCTRL-1:1] == '0) state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_FAULT: begin
                ctrl_n = '0;
                if (!en) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                ctrl_n  = '0;
            end
        endcase
    end

    assign ready = (state == S_ON);
    assign busy  = (state == S_WAIT_OK) || (state == S_RAMP) || (state == S_RAMPDN);
    assign fault = (state == S_FAULT);

endmodule

// File: tb/tb_asic_ioring_ctrl.sv
// Randomized and directed bench for asic_ioring_ctrl against a level/step-time
// reference model of the ring sequence.
module tb_asic_ioring_ctrl;

    localparam int NCTRL     = 8;
    localparam int CW        = 4;
    localparam int TMO_LIMIT = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             nreset;
    logic             en;
    logic             sense_ok;
    logic [CW-1:0]    dly;
    logic [NCTRL-1:0] ctrl;
    logic             ready;
    logic             busy;
    logic             fault;

    always #5 clk = ~clk;

    asic_ioring_ctrl #(.NCTRL(NCTRL), .CW(CW)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .en       (en),
        .sense_ok (sense_ok),
        .dly      (dly),
        .ctrl     (ctrl),
        .ready    (ready),
        .busy     (busy),
        .fault    (fault)
    );

    typedef enum int {M_IDLE, M_WAIT, M_RAMP, M_ON, M_DOWN, M_FAULT} mode_t;

    mode_t m_mode;
    int    m_level;     // number of ctrl bits currently on
    int    m_elapsed;   // cycles spent in the current ramp direction
    int    m_waited;    // cycles spent waiting for supply good
    int    m_dly;
    bit    m_s1, m_s2;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NCTRL-1:0] therm(input int level);
        logic [63:0] t;
        t = (64'd1 << level) - 64'd1;
        return t[NCTRL-1:0];
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_level   = 0;
        m_elapsed = 0;
        m_waited  = 0;
        m_dly     = 0;
        m_s1      = 0;
        m_s2      = 0;
    endtask

    task automatic model_step();
        bit ss;
        int period;
        ss     = m_s2;
        m_s2   = m_s1;
        m_s1   = sense_ok;
        period = m_dly + 1;
        case (m_mode)
            M_IDLE: if (en) begin
                m_mode   = M_WAIT;
                m_dly    = int'(dly);
                m_waited = 0;
            end
            M_WAIT: begin
                if (!en) m_mode = M_IDLE;
                else if (ss) begin
                    m_mode    = M_RAMP;
                    m_elapsed = 0;
                end else begin
                    m_waited++;
                    if (m_waited >= TMO_LIMIT) m_mode = M_FAULT;
                end
            end
            M_RAMP: begin
                if (!ss) begin
                    m_mode  = M_FAULT;
                    m_level = 0;
                end else if (!en) begin
                    m_mode    = M_DOWN;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed % period == 0) begin
                        m_level++;
                        if (m_level == NCTRL) m_mode = M_ON;
                    end
                end
            end
            M_ON: begin
                if (!ss) begin
                    m_mode  = M_FAULT;
                    m_level = 0;
                end else if (!en) begin
                    m_mode    = M_DOWN;
                    m_elapsed = 0;
                end
            end
            M_DOWN: begin
                if (!ss) begin
                    m_mode  = M_FAULT;
                    m_level = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed % period == 0) begin
                        if (m_level > 0) m_level--;
                        if (m_level == 0) m_mode = M_IDLE;
                    end
                end
            end
            M_FAULT: if (!en) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        check_eq("ctrl",  ctrl,  therm(m_level));
        check_eq("ready", ready, m_mode == M_ON);
        check_eq("busy",  busy,  (m_mode == M_WAIT) || (m_mode == M_RAMP) || (m_mode == M_DOWN));
        check_eq("fault", fault, m_mode == M_FAULT);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until(input mode_t target, input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            if (m_mode == target) break;
            tick();
        end
        check_eq(tag, m_mode == target, 1'b1);
    endtask

    initial begin
        int ramp_cycles;
        nreset   = 1'b0;
        en       = 1'b0;
        sense_ok = 1'b0;
        dly      = '0;
        model_reset();
        #2;
        check_outputs();
        #10 nreset = 1'b1;
        run(3);

        // full ramp with dly=2: 24 cycles from RAMP entry to ready
        sense_ok = 1'b1;
        dly      = CW'(2);
        en       = 1'b1;
        run_until(M_RAMP, 20, "reach_ramp");
        ramp_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready) break;
            tick();
            ramp_cycles++;
        end
        check_eq("ramp_len", ramp_cycles, NCTRL * 3);
        check_eq("ramp_full", ctrl, 8'hFF);

        en = 1'b0;
        run_until(M_IDLE, 60, "down_idle");

        // dly=0 ramp, then one-bit-per-edge ramp down
        dly = '0;
        en  = 1'b1;
        run_until(M_ON, 30, "fast_on");
        dly = CW'(9);
        en  = 1'b0;
        run_until(M_IDLE, 20, "fast_down");
        run(2);

        // power-up timeout with supply never good
        sense_ok = 1'b0;
        run(3);
        en = 1'b1;
        run_until(M_FAULT, 30, "tmo_fault");
        check_eq("tmo_flag", fault, 1'b1);
        run(3);
        en = 1'b0;
        tick();
        check_eq("tmo_clear", fault, 1'b0);

        // supply drop halfway through a ramp
        sense_ok = 1'b1;
        dly      = CW'(1);
        en       = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (m_mode == M_RAMP && m_level == 4) break;
            tick();
        end
        check_eq("mid_ramp", ctrl, 8'h0F);
        sense_ok = 1'b0;
        run(3);
        check_eq("drop_ctrl", ctrl, 8'h00);
        check_eq("drop_fault", fault, 1'b1);
        en = 1'b0;
        run(2);

        // async reset while ring is on, en held high
        sense_ok = 1'b1;
        en       = 1'b1;
        run_until(M_ON, 60, "pre_rst_on");
        #3 nreset = 1'b0;
        #1;
        model_reset();
        check_eq("rst_ctrl", ctrl, 8'h00);
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #2 nreset = 1'b1;
        #1 check_outputs();
        run_until(M_ON, 60, "post_rst_on");

        // en bounced during ramp-down is ignored until IDLE
        dly = CW'(3);
        en  = 1'b0;
        run(3);
        en = 1'b1;
        run(3);
        en = 1'b0;
        run(2);
        en = 1'b1;
        run_until(M_IDLE, 60, "bounce_idle");
        tick();
        check_eq("bounce_wait", busy, 1'b1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            if (sense_ok && $urandom_range(0, 249) == 0) sense_ok = 1'b0;
            else if (!sense_ok && $urandom_range(0, 7) == 0) sense_ok = 1'b1;
            dly = CW'($urandom_range(0, 3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
